mem_arbiter: RTL and testbench

Two-master arbiter that shares the single data-side master port of `simple_interconnect` between the core (M0) and a streaming master such as an audio sample DMA (M1). Each cycle it grants at most one request using round-robin, with optional bounded burst locking. It forwards the winner's write/address/data downstream and routes the synchronous read data back to the issuing master after a fixed latency.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_arbiter : two-master round-robin arbiter with bounded burst locking
//               and a fixed-latency read-return tag pipeline.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int LATENCY   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wd,
    input  logic [31:0] m1_wd,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rd,
    output logic [31:0] m1_rd,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wd,
    input  logic [31:0] s_rd,
    output logic        owner
);

    localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

    logic               last_q, last_d;
    logic               locked_q, locked_d;
    logic [7:0]         bcnt_q, bcnt_d;
    logic [LATENCY-1:0] tv_q;
    logic [LATENCY-1:0] tid_q;

    logic sel0, sel1, forced, acc, acc_id, acc_we, acc_lock;

    // Grant selection; a locked owner keeps the port until its burst budget is spent.
    always_comb begin
        sel0   = 1'b0;
        sel1   = 1'b0;
        forced = 1'b0;
        if (reset) begin
            if (m0_req && !m1_req) begin
                sel0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                sel1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (locked_q && (bcnt_q < C_MAX_BURST)) begin
                    sel0 = ~last_q;
                    sel1 = last_q;
                end else begin
                    sel0   = last_q;
                    sel1   = ~last_q;
                    forced = locked_q;
                end
            end
        end
    end

    assign acc      = sel0 | sel1;
    assign acc_id   = sel1;
    assign acc_we   = sel1 ? m1_we   : m0_we;
    assign acc_lock = sel1 ? m1_lock : m0_lock;

    always_comb begin
        last_d   = last_q;
        locked_d = locked_q;
        bcnt_d   = bcnt_q;
        if (acc) begin
            last_d   = acc_id;
            locked_d = forced ? 1'b0 : acc_lock;
            if ((acc_id == last_q) && locked_q) begin
                bcnt_d = (bcnt_q < C_MAX_BURST) ? bcnt_q + 8'd1 : C_MAX_BURST;
            end else begin
                bcnt_d = 8'd1;
            end
        end else begin
            locked_d = 1'b0;
            bcnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q   <= 1'b1;
            locked_q <= 1'b0;
            bcnt_q   <= 8'd0;
            tv_q     <= '0;
            tid_q    <= '0;
        end else begin
            last_q   <= last_d;
            locked_q <= locked_d;
            bcnt_q   <= bcnt_d;
            tv_q[0]  <= acc & ~acc_we;
            tid_q[0] <= acc_id;
            for (int i = 1; i < LATENCY; i++) begin
                tv_q[i]  <= tv_q[i-1];
                tid_q[i] <= tid_q[i-1];
            end
        end
    end

    assign m0_gnt    = sel0;
    assign m1_gnt    = sel1;
    assign s_we      = acc & acc_we;
    assign s_addr    = sel1 ? m1_addr : (sel0 ? m0_addr : 32'd0);
    assign s_wd      = sel1 ? m1_wd   : (sel0 ? m0_wd   : 32'd0);
    assign m0_rvalid = tv_q[LATENCY-1] & ~tid_q[LATENCY-1];
    assign m1_rvalid = tv_q[LATENCY-1] &  tid_q[LATENCY-1];
    assign m0_rd     = s_rd;
    assign m1_rd     = s_rd;
    assign owner     = last_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed test of mem_arbiter at LATENCY=1/MAX_BURST=4
//                  and LATENCY=3/MAX_BURST=8 sharing one stimulus stream.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd, s_rd;

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_we, owner;
    logic [31:0] m0_rd, m1_rd, s_addr, s_wd;
    logic        m0_gnt_3, m1_gnt_3, m0_rvalid_3, m1_rvalid_3, s_we_3, owner_3;
    logic [31:0] m0_rd_3, m1_rd_3, s_addr_3, s_wd_3;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.LATENCY(1), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_we(m0_we), .m1_we(m1_we), .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wd(m0_wd), .m1_wd(m1_wd), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rd(m0_rd), .m1_rd(m1_rd),
        .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd), .s_rd(s_rd), .owner(owner)
    );

    mem_arbiter #(.LATENCY(3), .MAX_BURST(8)) dut3 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_we(m0_we), .m1_we(m1_we), .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wd(m0_wd), .m1_wd(m1_wd), .m0_gnt(m0_gnt_3), .m1_gnt(m1_gnt_3),
        .m0_rvalid(m0_rvalid_3), .m1_rvalid(m1_rvalid_3), .m0_rd(m0_rd_3), .m1_rd(m1_rd_3),
        .s_we(s_we_3), .s_addr(s_addr_3), .s_wd(s_wd_3), .s_rd(s_rd), .owner(owner_3)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        m0_we = 1'b0; m1_we = 1'b0; m0_addr = '0; m1_addr = '0;
        m0_wd = '0; m1_wd = '0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [9:0] exp_m1g;
    logic [6:0] exp_rv0, exp_rv1;

    initial begin
        // Reset state, with a pending write request that must stay blocked
        idle_in();
        s_rd = 32'h0;
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1234; m0_wd = 32'hFF;
        tick(); tick(); #1;
        chk1("rst_m0_gnt", m0_gnt, 1'b0);
        chk1("rst_m1_gnt", m1_gnt, 1'b0);
        chk1("rst_s_we", s_we, 1'b0);
        chk32("rst_s_addr", s_addr, 32'h0);
        chk32("rst_s_wd", s_wd, 32'h0);
        chk1("rst_owner", owner, 1'b1);
        chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
        chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
        idle_in();
        reset = 1'b1;
        tick();

        // Single master: three back-to-back M0 reads
        for (int k = 0; k < 3; k++) begin
            m0_req = 1'b1; m0_addr = 32'h0000_1004;
            s_rd = 32'hA000_0000 + 32'(k);
            #1;
            chk1("t1_m0_gnt", m0_gnt, 1'b1);
            chk1("t1_m1_gnt", m1_gnt, 1'b0);
            chk32("t1_s_addr", s_addr, 32'h0000_1004);
            chk1("t1_s_we", s_we, 1'b0);
            chk1("t1_m0_rvalid", m0_rvalid, k > 0);
            chk32("t1_m0_rd", m0_rd, 32'hA000_0000 + 32'(k));
            chk1("t1_m1_rvalid", m1_rvalid, 1'b0);
            tick();
        end
        idle_in(); #1;
        chk1("t1_last_rvalid", m0_rvalid, 1'b1);
        chk1("t1_last_m1rv", m1_rvalid, 1'b0);
        tick(); #1;
        chk1("t1_rvalid_end", m0_rvalid, 1'b0);

        // Round-robin, both requesting continuously, no lock
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1("t2_m0_gnt", m0_gnt, k % 2 == 0);
            chk1("t2_m1_gnt", m1_gnt, k % 2 == 1);
            chk32("t2_s_addr", s_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            if (k > 0) begin
                chk1("t2_m0_rvalid", m0_rvalid, k % 2 == 1);
                chk1("t2_m1_rvalid", m1_rvalid, k % 2 == 0);
            end
            tick();
        end
        idle_in(); #1;
        chk1("t2_end_m1_rvalid", m1_rvalid, 1'b1);
        chk1("t2_end_m0_rvalid", m0_rvalid, 1'b0);
        chk1("t2_owner", owner, 1'b1);

        // Burst limit (MAX_BURST=4): M1 locked, M0 joins from cycle 2
        do_reset();
        exp_m1g = 10'b01111_01111;
        m1_req = 1'b1; m1_lock = 1'b1;
        for (int k = 0; k < 10; k++) begin
            m0_req = (k >= 2);
            #1;
            chk1("t3_m1_gnt", m1_gnt, exp_m1g[k]);
            chk1("t3_m0_gnt", m0_gnt, ~exp_m1g[k]);
            if (k > 0) chk1("t3_owner", owner, exp_m1g[k-1]);
            tick();
        end

        // Lock held with M0 idle: count saturates, M0 then wins at once
        do_reset();
        m1_req = 1'b1; m1_lock = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk1("t3b_m1_gnt", m1_gnt, 1'b1);
            tick();
        end
        m0_req = 1'b1; #1;
        chk1("t3b_m0_forced", m0_gnt, 1'b1);
        chk1("t3b_m1_wait", m1_gnt, 1'b0);
        tick(); #1;
        chk1("t3b_m1_rr", m1_gnt, 1'b1);

        // Write masking: M0 write, then M1 read
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_1000; m0_wd = 32'hDEAD_BEEF;
        #1;
        chk1("t4_m0_gnt", m0_gnt, 1'b1);
        chk1("t4_s_we_wr", s_we, 1'b1);
        chk32("t4_s_addr_wr", s_addr, 32'h0000_1000);
        chk32("t4_s_wd_wr", s_wd, 32'hDEAD_BEEF);
        tick();
        idle_in();
        m1_req = 1'b1; m1_addr = 32'h1000_0000; m1_wd = 32'h55;
        #1;
        chk1("t4_m1_gnt", m1_gnt, 1'b1);
        chk1("t4_s_we_rd", s_we, 1'b0);
        chk32("t4_s_addr_rd", s_addr, 32'h1000_0000);
        chk32("t4_s_wd_rd", s_wd, 32'h55);
        chk1("t4_no_wr_rvalid", m0_rvalid, 1'b0);
        tick();
        idle_in(); #1;
        chk1("t4_m1_rvalid", m1_rvalid, 1'b1);
        chk1("t4_m0_rvalid", m0_rvalid, 1'b0);
        chk1("t4_idle_s_we", s_we, 1'b0);
        chk32("t4_idle_s_addr", s_addr, 32'h0);
        chk32("t4_idle_s_wd", s_wd, 32'h0);
        tick(); #1;
        chk1("t4_m1_rvalid_end", m1_rvalid, 1'b0);

        // LATENCY=3: reads M0, M1, M0 then idle
        do_reset();
        exp_rv0 = 7'b0101000;
        exp_rv1 = 7'b0010000;
        for (int k = 0; k < 7; k++) begin
            idle_in();
            if (k == 0) begin m0_req = 1'b1; m0_addr = 32'h10; end
            if (k == 1) begin m1_req = 1'b1; m1_addr = 32'h20; end
            if (k == 2) begin m0_req = 1'b1; m0_addr = 32'h30; end
            #1;
            if (k < 3) chk1("t5_gnt", m0_gnt_3 | m1_gnt_3, 1'b1);
            chk1("t5_m0_rvalid", m0_rvalid_3, exp_rv0[k]);
            chk1("t5_m1_rvalid", m1_rvalid_3, exp_rv1[k]);
            tick();
        end

        // Reset one cycle after an accepted M0 read (LATENCY=3 instance)
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h40;
        #1;
        chk1("t6_m0_gnt", m0_gnt_3, 1'b1);
        tick();
        m0_we = 1'b1;
        reset = 1'b0;
        #1;
        chk1("t6_owner", owner_3, 1'b1);
        chk1("t6_s_we", s_we_3, 1'b0);
        chk1("t6_gnt", m0_gnt_3, 1'b0);
        chk1("t6_rvalid_in_rst", m0_rvalid_3, 1'b0);
        tick();
        idle_in();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("t6_m0_rvalid", m0_rvalid_3, 1'b0);
            chk1("t6_m1_rvalid", m1_rvalid_3, 1'b0);
            chk1("t6_m0_rvalid_l1", m0_rvalid, 1'b0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
